aexm_hazard_unit: RTL and testbench

- Parametrised successor to the AEXM decode-stage control: per-stage destination scoreboard, operand-forwarding select generation for three source operands (A, B, store-data D), and a decode stall.
- Generalised over register-address width, pipeline depth, load latency and multi-cycle op latency.
- Sits beside decode and drives the operand muxes and the global decode stall.

---
 rtl/aexm_hazard_unit.sv | 179 +++++++++++++++++
 tb/tb_aexm_hazard_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aexm_hazard_unit.sv
// -----------------------------------------------------------------------------
// aexm_hazard_unit
//
// Decode-side hazard control for the AEXM pipeline. It tracks the destination
// register of every in-flight instruction (one scoreboard entry per stage after
// decode), generates forwarding selects for the three decode source operands,
// and produces the global decode stall for load-use hazards and for
// multi-cycle (barrel shift) operations.
//
// Parameters
//   AW        register address width
//   DEPTH     tracked stages after decode (1 = execute ... DEPTH = writeback)
//   LOAD_LAT  first stage index at which a load result can be forwarded
//   MC_LAT    issue occupancy of a multi-cycle op, in d_en cycles
//
// Ports
//   gclk, grst_n      clock (rising edge), asynchronous active-low reset
//   d_en              pipeline advance enable
//   x_skip            squash the instruction currently in stage 1
//   d_valid/d_we/d_load/d_multi   decode instruction attributes
//   d_rd              decode destination register
//   d_ra/d_rb/d_rs    decode sources A, B and store data
//   a_sel/b_sel/s_sel forwarding selects: 0 = regfile, k = stage k result
//   stall             hold decode and insert a bubble into stage 1
//   wb_rd/wb_we       destination and write enable of the last tracked stage
// -----------------------------------------------------------------------------
module aexm_hazard_unit #(
  parameter int  AW       = 5,
  parameter int  DEPTH    = 3,
  parameter int  LOAD_LAT = 2,
  parameter int  MC_LAT   = 4,
  localparam int SW       = $clog2(DEPTH + 1)
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          d_en,
  input  logic          x_skip,
  input  logic          d_valid,
  input  logic          d_we,
  input  logic          d_load,
  input  logic          d_multi,
  input  logic [AW-1:0] d_rd,
  input  logic [AW-1:0] d_ra,
  input  logic [AW-1:0] d_rb,
  input  logic [AW-1:0] d_rs,
  output logic [SW-1:0] a_sel,
  output logic [SW-1:0] b_sel,
  output logic [SW-1:0] s_sel,
  output logic          stall,
  output logic [AW-1:0] wb_rd,
  output logic          wb_we
);

  // Counter only ever holds MC_LAT-1 down to 1.
  localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          ld;
  } entry_t;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  entry_t          sb [1:DEPTH];
  logic [DEPTH:1]  eff_v;
  logic [AW-1:0]   src     [3];
  logic [SW-1:0]   raw_sel [3];
  logic [2:0]      hz;
  logic            load_hz;
  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;

  // ---------------------------------------------------------------------------
  // Scoreboard shift register
  // ---------------------------------------------------------------------------
  // NOTE: every entry is cleared on reset, not just the valid bits, so wb_rd
  // reads 0 while in reset and the array never carries X into the compares.
  // NOTE: sequential state uses non-blocking assignments so each entry samples
  // its neighbour's pre-edge value and the shift happens in one step.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sb[k] <= '0;
      end
    end else if (d_en) begin
      // A stalled decode enters stage 1 as a bubble; r0 is never recorded.
      sb[1] <= '{v:  d_valid & d_we & (d_rd != '0) & ~stall,
                 rd: d_rd,
                 ld: d_load};
      // A squashed stage-1 instruction moves on but no longer writes.
      sb[2] <= '{v: sb[1].v & ~x_skip, rd: sb[1].rd, ld: sb[1].ld};
      for (int k = 3; k <= DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      eff_v[k] = sb[k].v;
    end
    eff_v[1] = sb[1].v & ~x_skip;
  end

  // ---------------------------------------------------------------------------
  // Forwarding lookup: youngest matching stage wins. Walking from the oldest
  // stage down lets the last hit (smallest k) overwrite older ones.
  // ---------------------------------------------------------------------------
  assign src[0] = d_ra;
  assign src[1] = d_rb;
  assign src[2] = d_rs;

  // NOTE: every combinational output is given a default before the loops so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      raw_sel[i] = '0;
      hz[i]      = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (src[i] != '0 && eff_v[k] && sb[k].rd == src[i]) begin
          raw_sel[i] = SW'(k);
          // Load data is not on the bypass network before LOAD_LAT.
          hz[i]      = sb[k].ld && (k < LOAD_LAT);
        end
      end
    end
  end

  assign load_hz = d_valid & (|hz);
  assign stall   = load_hz | (state == BUSY);

  // A source waiting on load data has nothing valid to forward yet.
  assign a_sel = (hz[0] & stall) ? '0 : raw_sel[0];
  assign b_sel = (hz[1] & stall) ? '0 : raw_sel[1];
  assign s_sel = (hz[2] & stall) ? '0 : raw_sel[2];

  assign wb_rd = sb[DEPTH].rd;
  assign wb_we = sb[DEPTH].v;

  // ---------------------------------------------------------------------------
  // Multi-cycle occupancy FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (d_en) begin
      case (state)
        IDLE: begin
          if (d_valid && d_multi && !stall && (MC_LAT > 1)) begin
            state_nx = BUSY;
            cnt_nx   = CW'(MC_LAT - 1);
          end
        end
        BUSY: begin
          cnt_nx = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aexm_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_aexm_hazard_unit
//
// Directed scenarios with hand-derived expectations, followed by a randomized
// run compared against a queue-based model of the in-flight instructions.
// A second instance built with MC_LAT = 1 shares the inputs.
// -----------------------------------------------------------------------------
module tb_aexm_hazard_unit;

  localparam int AW       = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int MC_LAT   = 4;
  localparam int SW       = $clog2(DEPTH + 1);

  logic          gclk = 1'b0;
  logic          grst_n = 1'b0;
  logic          d_en = 1'b0, x_skip = 1'b0, d_valid = 1'b0, d_we = 1'b0;
  logic          d_load = 1'b0, d_multi = 1'b0;
  logic [AW-1:0] d_rd = '0, d_ra = '0, d_rb = '0, d_rs = '0;
  logic [SW-1:0] a_sel, b_sel, s_sel;
  logic          stall, wb_we;
  logic [AW-1:0] wb_rd;
  logic [SW-1:0] a_sel1, b_sel1, s_sel1;
  logic          stall1, wb_we1;
  logic [AW-1:0] wb_rd1;

  int total = 0;
  int bad   = 0;

  always #5 gclk = ~gclk;

  aexm_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .MC_LAT(MC_LAT)) u_dut (
    .gclk(gclk), .grst_n(grst_n), .d_en(d_en), .x_skip(x_skip),
    .d_valid(d_valid), .d_we(d_we), .d_load(d_load), .d_multi(d_multi),
    .d_rd(d_rd), .d_ra(d_ra), .d_rb(d_rb), .d_rs(d_rs),
    .a_sel(a_sel), .b_sel(b_sel), .s_sel(s_sel), .stall(stall),
    .wb_rd(wb_rd), .wb_we(wb_we)
  );

  aexm_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .MC_LAT(1)) u_dut1 (
    .gclk(gclk), .grst_n(grst_n), .d_en(d_en), .x_skip(x_skip),
    .d_valid(d_valid), .d_we(d_we), .d_load(d_load), .d_multi(d_multi),
    .d_rd(d_rd), .d_ra(d_ra), .d_rb(d_rb), .d_rs(d_rs),
    .a_sel(a_sel1), .b_sel(b_sel1), .s_sel(s_sel1), .stall(stall1),
    .wb_rd(wb_rd1), .wb_we(wb_we1)
  );

  // ---------------------------------------------------------------------------
  // Reference model: a queue of in-flight instructions, index 0 = stage 1,
  // plus a count of remaining multi-cycle occupancy cycles.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          v;
    logic [AW-1:0] rd;
    logic          ld;
  } ent_t;

  ent_t          pipe[$];
  int            busy_left;
  logic [SW-1:0] exp_a, exp_b, exp_s;
  logic          exp_stall, exp_wb_we;
  logic [AW-1:0] exp_wb_rd;

  function automatic void model_reset();
    ent_t e;
    e.v = 1'b0; e.rd = '0; e.ld = 1'b0;
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
    busy_left = 0;
  endfunction

  function automatic void model_find(input logic [AW-1:0] s, output int k, output bit h);
    k = 0;
    h = 1'b0;
    if (s == '0) return;
    for (int i = 0; i < pipe.size(); i++) begin
      if (pipe[i].v && !(i == 0 && x_skip) && pipe[i].rd == s) begin
        k = i + 1;
        h = pipe[i].ld && ((i + 1) < LOAD_LAT);
        return;
      end
    end
  endfunction

  function automatic void model_eval();
    int ka, kb, ks;
    bit ha, hb, hs;
    model_find(d_ra, ka, ha);
    model_find(d_rb, kb, hb);
    model_find(d_rs, ks, hs);
    exp_stall = (d_valid && (ha || hb || hs)) || (busy_left > 0);
    exp_a     = (ha && exp_stall) ? '0 : SW'(ka);
    exp_b     = (hb && exp_stall) ? '0 : SW'(kb);
    exp_s     = (hs && exp_stall) ? '0 : SW'(ks);
    exp_wb_rd = pipe[DEPTH-1].rd;
    exp_wb_we = pipe[DEPTH-1].v;
  endfunction

  function automatic void model_advance();
    ent_t e;
    bit   st;
    if (!d_en) return;
    model_eval();
    st = exp_stall;
    if (busy_left > 0) busy_left--;
    else if (d_valid && d_multi && !st && MC_LAT > 1) busy_left = MC_LAT - 1;
    if (x_skip) pipe[0].v = 1'b0;
    e.v  = d_valid && d_we && (d_rd != '0) && !st;
    e.rd = d_rd;
    e.ld = d_load;
    pipe.push_front(e);
    void'(pipe.pop_back());
  endfunction

  // Inputs change in the low phase; outputs are sampled 1 time unit later.
  task automatic drive(input logic en, input logic skip, input logic valid,
                       input logic we, input logic ld, input logic multi,
                       input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb, input logic [AW-1:0] rs);
    d_en = en; x_skip = skip; d_valid = valid; d_we = we;
    d_load = ld; d_multi = multi;
    d_rd = rd; d_ra = ra; d_rb = rb; d_rs = rs;
    #1;
  endtask

  task automatic tick();
    model_advance();
    @(posedge gclk);
    @(negedge gclk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge gclk);
    #1;
    total++;
    if ({a_sel, b_sel, s_sel, stall, wb_rd, wb_we} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got a=%0d b=%0d s=%0d stall=%0b wb_rd=%0d wb_we=%0b, want all 0",
               a_sel, b_sel, s_sel, stall, wb_rd, wb_we);
    end
    @(negedge gclk);
    grst_n = 1'b1;
    model_reset();
    drive(1, 0, 1, 0, 0, 0, 0, 1, 2, 3);
    total++;
    if ({a_sel, b_sel, s_sel, stall, wb_we} !== '0) begin
      bad++;
      $display("FAIL reset_release: got a=%0d b=%0d s=%0d stall=%0b wb_we=%0b, want all 0",
               a_sel, b_sel, s_sel, stall, wb_we);
    end
    tick();
  endtask

  task automatic test_fwd_distance();
    int want;
    drive(1, 0, 1, 1, 0, 0, 5, 0, 0, 0);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL fwd_write_stall: got %0b want 0", stall); end
    tick();
    for (int d = 1; d <= 4; d++) begin
      want = (d <= 3) ? d : 0;
      drive(1, 0, 1, 0, 0, 0, 0, 5, 0, 0);
      total++;
      if (a_sel !== SW'(want) || stall !== 1'b0) begin
        bad++;
        $display("FAIL fwd_dist%0d: got a_sel=%0d stall=%0b want a_sel=%0d stall=0", d, a_sel, stall, want);
      end
      if (d == 3) begin
        total++;
        if (wb_we !== 1'b1 || wb_rd !== 5'd5) begin
          bad++;
          $display("FAIL fwd_wb: got wb_we=%0b wb_rd=%0d want 1/5", wb_we, wb_rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    drive(1, 0, 1, 1, 1, 0, 7, 0, 0, 0);
    tick();
    drive(1, 0, 1, 1, 0, 0, 8, 0, 7, 0);
    total++;
    if (stall !== 1'b1 || b_sel !== '0) begin
      bad++;
      $display("FAIL load_use_stall: got stall=%0b b_sel=%0d want 1/0", stall, b_sel);
    end
    tick();
    drive(1, 0, 1, 1, 0, 0, 8, 8, 7, 0);
    total++;
    if (stall !== 1'b0 || b_sel !== 2'd2 || a_sel !== '0) begin
      bad++;
      $display("FAIL load_use_release: got stall=%0b b_sel=%0d a_sel=%0d want 0/2/0", stall, b_sel, a_sel);
    end
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 8, 0, 0);
    total++;
    if (a_sel !== 2'd1) begin bad++; $display("FAIL load_use_retry: got a_sel=%0d want 1", a_sel); end
    tick();
    drive(1, 0, 1, 1, 1, 0, 7, 0, 0, 0);
    tick();
    drive(1, 0, 1, 1, 0, 0, 9, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 7, 0);
    total++;
    if (stall !== 1'b0 || b_sel !== 2'd2) begin
      bad++;
      $display("FAIL load_gap: got stall=%0b b_sel=%0d want 0/2", stall, b_sel);
    end
    tick();
  endtask

  task automatic test_skip();
    drive(1, 0, 1, 1, 0, 0, 3, 0, 0, 0);
    tick();
    drive(1, 0, 1, 1, 0, 0, 3, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 3, 3, 3);
    total++;
    if (a_sel !== 2'd1 || b_sel !== 2'd1 || s_sel !== 2'd1) begin
      bad++;
      $display("FAIL youngest_wins: got a=%0d b=%0d s=%0d want 1/1/1", a_sel, b_sel, s_sel);
    end
    drive(1, 1, 1, 0, 0, 0, 0, 3, 3, 3);
    total++;
    if (a_sel !== 2'd2 || b_sel !== 2'd2 || s_sel !== 2'd2) begin
      bad++;
      $display("FAIL skip_sel: got a=%0d b=%0d s=%0d want 2/2/2", a_sel, b_sel, s_sel);
    end
    tick();
  endtask

  task automatic test_r0();
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (a_sel !== '0 || b_sel !== '0 || s_sel !== '0) begin
      bad++;
      $display("FAIL r0_sel: got a=%0d b=%0d s=%0d want 0/0/0", a_sel, b_sel, s_sel);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (wb_we !== 1'b0) begin bad++; $display("FAIL r0_wb_we: got %0b want 0", wb_we); end
  endtask

  task automatic test_multi();
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL multi_accept: got stall=%0b want 0", stall); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++;
      if (stall !== 1'b1 || stall1 !== 1'b0) begin
        bad++;
        $display("FAIL multi_busy%0d: got stall=%0b stall_mc1=%0b want 1/0", i, stall, stall1);
      end
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL multi_done: got stall=%0b want 0", stall); end
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive((i != 1), 0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++;
      if (stall !== 1'b1) begin
        bad++;
        $display("FAIL multi_hold%0d: got stall=%0b want 1", i, stall);
      end
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL multi_hold_done: got stall=%0b want 0", stall); end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 1, 1, 0, 0, 2, 0, 0, 0);
    tick();
    drive(1, 0, 1, 1, 1, 0, 3, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 1, 3, 0);
    total++;
    if (stall !== 1'b1 || a_sel !== 2'd3 || wb_we !== 1'b1) begin
      bad++;
      $display("FAIL prereset: got stall=%0b a_sel=%0d wb_we=%0b want 1/3/1", stall, a_sel, wb_we);
    end
    grst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (stall !== 1'b0 || a_sel !== '0 || b_sel !== '0 || wb_we !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: got stall=%0b a=%0d b=%0d wb_we=%0b want 0", stall, a_sel, b_sel, wb_we);
    end
    @(negedge gclk);
    grst_n = 1'b1;
    drive(1, 0, 1, 0, 0, 0, 0, 2, 1, 0);
    total++;
    if (stall !== 1'b0 || a_sel !== '0 || b_sel !== '0) begin
      bad++;
      $display("FAIL post_reset: got stall=%0b a=%0d b=%0d want 0/0/0", stall, a_sel, b_sel);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
            AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
      model_eval();
      total++;
      if (a_sel !== exp_a || b_sel !== exp_b || s_sel !== exp_s) begin
        bad++;
        $display("FAIL rand_sel@%0d: got a=%0d b=%0d s=%0d want a=%0d b=%0d s=%0d",
                 n, a_sel, b_sel, s_sel, exp_a, exp_b, exp_s);
      end
      total++;
      if (stall !== exp_stall) begin
        bad++;
        $display("FAIL rand_stall@%0d: got %0b want %0b", n, stall, exp_stall);
      end
      total++;
      if (wb_we !== exp_wb_we || wb_rd !== exp_wb_rd) begin
        bad++;
        $display("FAIL rand_wb@%0d: got we=%0b rd=%0d want we=%0b rd=%0d",
                 n, wb_we, wb_rd, exp_wb_we, exp_wb_rd);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fwd_distance();
    test_load_use();
    test_skip();
    test_r0();
    test_multi();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
